buffer_idex_skid: RTL and testbench
===================================

# buffer_idex_skid

Parametrised ID/EX pipeline register with valid/ready flow control, a one-entry skid buffer, and synchronous flush. It sits between the decode stage (register-file reads, control decode) and the execute stage (ALU). It carries ALU opcode, register-destination select, two operands, destination register field and function field. It lets execute stall without dropping a word, and lets hazard/branch logic squash in-flight instructions as bubbles.

## Interface
- DATA_W, 32, operand width
- ALUOP_W, 3, ALU opcode width
- RD_W, 5, destination register field width
- FUNCT_W, 6, function field width
- BUBBLE_ALUOP, 0, ALU opcode driven when no valid instruction is presented
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; 0 while rst is high, else equals NOT skid_valid
- in_aluop  in  ALUOP_W  ALU opcode
- in_regdst  in  1  register-destination select
- in_data1, in_data2  in  DATA_W  operands
- in_rd  in  RD_W  destination register field
- in_funct  in  FUNCT_W  function field
- flush  in  1  synchronous squash of all held instructions
- out_valid  out  1  output register holds a valid instruction
- out_ready  in  1  execute accepts this cycle
- out_aluop, out_regdst, out_data1, out_data2, out_rd, out_funct  out  widths as inputs  registered payload
- occupancy  out  2  out_valid + skid_valid (0..2)

## Operation
- Storage: main register (drives outputs) plus one skid register, each with a valid bit.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Priority order at each edge: rst (async), then flush, then normal transfer.
- Normal transfer when main is empty or out_fire:
  - Skid valid: main loads from skid and skid clears; in_ready was 0, so nothing is accepted.
  - Else if in_fire: main loads from the inputs.
  - Else: main valid goes to 0.
- Normal transfer when main is full and out_ready=0:
  - Main holds.
  - If in_fire, the input goes to skid; skid is always empty when in_fire is possible.
- Order is preserved at all times: skid content is always younger than main content.
- Flush edge:
  - main_valid and skid_valid both go to 0.
  - out_aluop becomes BUBBLE_ALUOP and out_regdst becomes 0.
  - Data, rd and funct fields hold their previous value.
  - An input accepted in the flush cycle (in_fire=1) is discarded.
- Bubble rule: whenever out_valid=0, out_aluop=BUBBLE_ALUOP and out_regdst=0, so execute sees a NOP even if it ignores out_valid.

## Timing
- Reset values:
  - out_valid=0, skid_valid=0, occupancy=0.
  - out_aluop=BUBBLE_ALUOP, out_regdst=0, out_data1=0, out_data2=0, out_rd=0, out_funct=0.
  - Skid payload 0.
  - in_ready=0 while rst=1.
- in_ready is 1 in the first cycle after rst deasserts.
- Latency: 1 cycle. An in_fire at edge N gives out_valid=1 with that payload after edge N.
- Throughput: 1 instruction/cycle while out_ready=1.
- Back-pressure:
  - The first out_ready=0 cycle with main full absorbs one extra word into skid.
  - in_ready drops in the following cycle. This relieves decode from a combinational path to out_ready.
- Recovery: after out_ready returns to 1, skid drains into main on the next edge and in_ready rises the cycle after.
- in_ready is a register output (no combinational path from out_ready or in_valid).
- Simultaneous flush and out_fire: flush wins. The word is considered consumed by execute, and nothing remains.
- rst asserted mid-transfer clears state immediately, regardless of clk.

## Test plan
- Reset then stream: rst high 2 cycles; in_valid=1, out_ready=1, in_data1 = 0x10, 0x11, 0x12 on consecutive cycles -> out_data1 shows 0x10, 0x11, 0x12 on the cycles after each edge; occupancy stays 1; in_ready stays 1.
- Stall with skid: main holds A (aluop=3); out_ready=0; present B -> B captured into skid, occupancy=2, in_ready=0 next cycle. Raise out_ready -> A consumed, then B, with no loss or duplication.
- Flush while full: occupancy=2 with A and B; assert flush one cycle -> out_valid=0, out_aluop=BUBBLE_ALUOP, out_regdst=0, occupancy=0, in_ready=1; the word offered during the flush cycle never appears.
- Flush with simultaneous out_fire and in_fire: A at output with out_ready=1, C offered at input, flush=1 -> next cycle out_valid=0 and C is not delivered.
- Async reset mid-stall: occupancy=2; pulse rst between clock edges -> all outputs go to reset values immediately; after release, a fresh word D=0xDEADBEEF passes with 1-cycle latency.
- Parameter sweep: DATA_W=64, ALUOP_W=4, BUBBLE_ALUOP=4'hF -> idle output shows out_aluop=0xF; 64-bit operand 0x0123456789ABCDEF passes unchanged.

Source files
------------

// File: rtl/buffer_idex_skid.sv
//------------------------------------------------------------------------------
// Module   : buffer_idex_skid
// Brief    : ID/EX pipeline register with valid/ready handshake, one-entry
//            skid buffer and synchronous flush that turns held words into bubbles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module buffer_idex_skid #(
  parameter int                   DATA_W       = 32,
  parameter int                   ALUOP_W      = 3,
  parameter int                   RD_W         = 5,
  parameter int                   FUNCT_W      = 6,
  parameter logic [ALUOP_W-1:0]   BUBBLE_ALUOP = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic               in_regdst,
  input  logic [DATA_W-1:0]  in_data1,
  input  logic [DATA_W-1:0]  in_data2,
  input  logic [RD_W-1:0]    in_rd,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic               out_regdst,
  output logic [DATA_W-1:0]  out_data1,
  output logic [DATA_W-1:0]  out_data2,
  output logic [RD_W-1:0]    out_rd,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [1:0]         occupancy
);

  localparam int c_CTL_W = ALUOP_W + 1;
  localparam int c_DAT_W = 2 * DATA_W + RD_W + FUNCT_W;
  localparam logic [c_CTL_W-1:0] c_BUBBLE_CTL = {BUBBLE_ALUOP, 1'b0};

  logic               r_main_valid;
  logic [c_CTL_W-1:0] r_main_ctl;
  logic [c_DAT_W-1:0] r_main_dat;
  logic               r_skid_valid;
  logic [c_CTL_W-1:0] r_skid_ctl;
  logic [c_DAT_W-1:0] r_skid_dat;

  logic               w_in_fire;
  logic [c_CTL_W-1:0] w_in_ctl;
  logic [c_DAT_W-1:0] w_in_dat;

  // in_ready depends only on stored state (and reset), never on out_ready/in_valid
  assign in_ready  = !rst && !r_skid_valid;
  assign w_in_fire = in_valid && in_ready;
  assign w_in_ctl  = {in_aluop, in_regdst};
  assign w_in_dat  = {in_data1, in_data2, in_rd, in_funct};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_ctl   <= c_BUBBLE_CTL;
      r_main_dat   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctl   <= '0;
      r_skid_dat   <= '0;
    end else if (flush) begin
      // Squash everything; data fields keep their last value
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_ctl   <= c_BUBBLE_CTL;
    end else if (!r_main_valid || out_ready) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_ctl   <= r_skid_ctl;
        r_main_dat   <= r_skid_dat;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_ctl   <= w_in_ctl;
        r_main_dat   <= w_in_dat;
      end else begin
        r_main_valid <= 1'b0;
        r_main_ctl   <= c_BUBBLE_CTL;
      end
    end else if (w_in_fire) begin
      // Main stalled: the younger word parks in the skid slot
      r_skid_valid <= 1'b1;
      r_skid_ctl   <= w_in_ctl;
      r_skid_dat   <= w_in_dat;
    end
  end

  assign out_valid = r_main_valid;
  assign {out_aluop, out_regdst} = r_main_ctl;
  assign {out_data1, out_data2, out_rd, out_funct} = r_main_dat;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

`default_nettype wire

// File: tb/tb_buffer_idex_skid.sv
//------------------------------------------------------------------------------
// Module   : tb_buffer_idex_skid
// Brief    : Self-checking bench for buffer_idex_skid against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_buffer_idex_skid;

  typedef struct packed {
    logic [2:0]  aluop;
    logic        regdst;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic [5:0]  funct;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  word_t       in_w = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_aluop;
  logic        out_regdst;
  logic [31:0] out_data1, out_data2;
  logic [4:0]  out_rd;
  logic [5:0]  out_funct;
  logic [1:0]  occupancy;

  // Wide-parameter instance
  logic        v2 = 1'b0;
  logic        rdy2;
  logic [3:0]  aluop2_i = '0;
  logic [63:0] d1_2_i = '0;
  logic        ov2;
  logic [3:0]  aluop2_o;
  logic        regdst2_o;
  logic [63:0] d1_2_o, d2_2_o;
  logic [4:0]  rd2_o;
  logic [5:0]  funct2_o;
  logic [1:0]  occ2;

  int n_checks = 0;
  int n_fail   = 0;

  word_t q[$];
  word_t last = '0;

  always #5 clk = ~clk;

  buffer_idex_skid dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_w.aluop), .in_regdst(in_w.regdst),
    .in_data1(in_w.d1), .in_data2(in_w.d2), .in_rd(in_w.rd), .in_funct(in_w.funct),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_regdst(out_regdst),
    .out_data1(out_data1), .out_data2(out_data2), .out_rd(out_rd), .out_funct(out_funct),
    .occupancy(occupancy)
  );

  buffer_idex_skid #(.DATA_W(64), .ALUOP_W(4), .BUBBLE_ALUOP(4'hF)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(v2), .in_ready(rdy2),
    .in_aluop(aluop2_i), .in_regdst(1'b1),
    .in_data1(d1_2_i), .in_data2(64'h0), .in_rd(5'd0), .in_funct(6'd0),
    .flush(1'b0),
    .out_valid(ov2), .out_ready(1'b1),
    .out_aluop(aluop2_o), .out_regdst(regdst2_o),
    .out_data1(d1_2_o), .out_data2(d2_2_o), .out_rd(rd2_o), .out_funct(funct2_o),
    .occupancy(occ2)
  );

  function automatic word_t mk(input logic [2:0] a, input logic r, input logic [31:0] x,
                               input logic [31:0] y, input logic [4:0] d, input logic [5:0] f);
    word_t w;
    w.aluop = a; w.regdst = r; w.d1 = x; w.d2 = y; w.rd = d; w.funct = f;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the queue of held words
  task automatic check_all();
    int sz = q.size();
    chk("out_valid", {63'd0, out_valid}, {63'd0, sz > 0});
    chk("occupancy", {62'd0, occupancy}, 64'(sz));
    chk("in_ready",  {63'd0, in_ready},  {63'd0, (!rst && sz < 2)});
    chk("out_aluop", {61'd0, out_aluop}, (sz > 0) ? {61'd0, q[0].aluop} : 64'd0);
    chk("out_regdst",{63'd0, out_regdst},(sz > 0) ? {63'd0, q[0].regdst} : 64'd0);
    chk("out_data1", {32'd0, out_data1}, {32'd0, last.d1});
    chk("out_data2", {32'd0, out_data2}, {32'd0, last.d2});
    chk("out_rd",    {59'd0, out_rd},    {59'd0, last.rd});
    chk("out_funct", {58'd0, out_funct}, {58'd0, last.funct});
  endtask

  task automatic step(input bit iv, input word_t w, input bit ordy, input bit fl);
    bit acc;
    in_valid = iv; in_w = w; out_ready = ordy; flush = fl;
    acc = iv && !rst && (q.size() < 2);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    if (q.size() > 0) last = q[0];
    #1;
    check_all();
  endtask

  function automatic word_t rnd_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[78:0];
  endfunction

  initial begin
    word_t a, b, c;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // Streaming
    step(1, mk(3'd1, 1'b1, 32'h10, 32'h1, 5'd1, 6'd1), 1, 0);
    step(1, mk(3'd2, 1'b0, 32'h11, 32'h2, 5'd2, 6'd2), 1, 0);
    step(1, mk(3'd5, 1'b1, 32'h12, 32'h3, 5'd3, 6'd3), 1, 0);
    step(0, '0, 1, 0);

    // Stall with skid, then drain in order
    a = mk(3'd3, 1'b1, 32'hAAAA_0001, 32'h1111, 5'd7, 6'h21);
    b = mk(3'd4, 1'b0, 32'hBBBB_0002, 32'h2222, 5'd9, 6'h22);
    c = mk(3'd6, 1'b1, 32'hCCCC_0003, 32'h3333, 5'd11, 6'h23);
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    step(1, c, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Flush while full, with a word offered in the flush cycle
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    step(1, c, 0, 1);
    step(0, '0, 1, 0);

    // Flush with simultaneous out_fire and in_fire
    step(1, a, 0, 0);
    step(1, c, 1, 1);
    step(0, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);

    // Async reset mid-stall
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    last = '0;
    check_all();
    chk("w_idle_aluop", {60'd0, aluop2_o}, 64'hF);
    chk("w_idle_data",  d1_2_o, 64'd0);
    #2 rst = 1'b0;
    step(1, mk(3'd2, 1'b0, 32'hDEADBEEF, 32'h0, 5'd4, 6'd0), 1, 0);
    step(0, '0, 1, 0);

    // Wide-parameter instance
    v2 = 1'b1; aluop2_i = 4'h5; d1_2_i = 64'h0123456789ABCDEF;
    step(0, '0, 1, 0);
    chk("w_valid", {63'd0, ov2}, 64'd1);
    chk("w_aluop", {60'd0, aluop2_o}, 64'h5);
    chk("w_data1", d1_2_o, 64'h0123456789ABCDEF);
    v2 = 1'b0;
    step(0, '0, 1, 0);
    chk("w_bubble_valid", {63'd0, ov2}, 64'd0);
    chk("w_bubble_aluop", {60'd0, aluop2_o}, 64'hF);
    chk("w_hold_data1", d1_2_o, 64'h0123456789ABCDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
